// File: rtl/heat_mode_sequencer.sv
// Heating mode sequencer: hysteresis-based OFF/ECO/BOOST/LOCKOUT controller
// with a minimum-dwell gate on temperature-driven transitions.
module heat_mode_sequencer #(
  parameter int unsigned TEMP_W      = 8,
  parameter int unsigned HYST        = 2,
  parameter int unsigned BOOST_DELTA = 5,
  parameter int unsigned MIN_DWELL   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [TEMP_W-1:0] temp_meas,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] setpoint,
  output logic [1:0]        mode,
  output logic              mode_select,
  output logic              heat_on,
  output logic [1:0]        state_o
);

  localparam int unsigned DW = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0]     DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [TEMP_W:0]   HYST_X    = (TEMP_W + 1)'(HYST);
  localparam logic [TEMP_W:0]   BOOST_X   = (TEMP_W + 1)'(BOOST_DELTA);
  localparam logic [TEMP_W:0]   TEMP_MAX  = {1'b0, {TEMP_W{1'b1}}};

  typedef enum logic [1:0] {
    ST_OFF     = 2'b00,
    ST_ECO     = 2'b01,
    ST_BOOST   = 2'b10,
    ST_LOCKOUT = 2'b11
  } state_t;

  state_t          state, next_state;
  logic [DW-1:0]   dwell;
  logic            dwell_expired;
  logic            qualified;
  logic [TEMP_W:0] temp_x, sp_x, lo_x, hi_raw, hi_x, deficit;
  logic            below_lo, at_hi, boost_need;
  logic [1:0]      mode_d;
  logic            select_d, heat_d;

  // Saturated thresholds and deficit in one-bit-wider arithmetic
  always_comb begin
    temp_x   = {1'b0, temp_meas};
    sp_x     = {1'b0, setpoint};
    lo_x     = (sp_x >= HYST_X) ? (sp_x - HYST_X) : '0;
    hi_raw   = sp_x + HYST_X;
    hi_x     = (hi_raw > TEMP_MAX) ? TEMP_MAX : hi_raw;
    deficit  = (temp_x >= sp_x) ? '0 : (sp_x - temp_x);
    below_lo   = temp_x < lo_x;
    at_hi      = temp_x >= hi_x;
    boost_need = deficit >= BOOST_X;
  end

  assign dwell_expired = (dwell == DWELL_MAX);
  assign qualified     = temp_valid && enable && dwell_expired;

  // Next-state selection; disable overrides dwell, lockout ignores samples
  always_comb begin
    next_state = state;
    case (state)
      ST_OFF: begin
        if (qualified && below_lo)
          next_state = boost_need ? ST_BOOST : ST_ECO;
      end
      ST_ECO: begin
        if (!enable)
          next_state = ST_OFF;
        else if (qualified) begin
          if (at_hi)           next_state = ST_LOCKOUT;
          else if (boost_need) next_state = ST_BOOST;
        end
      end
      ST_BOOST: begin
        if (!enable)
          next_state = ST_OFF;
        else if (qualified) begin
          if (at_hi)            next_state = ST_LOCKOUT;
          else if (!boost_need) next_state = ST_ECO;
        end
      end
      ST_LOCKOUT: begin
        if (dwell_expired)
          next_state = ST_OFF;
      end
      default: next_state = ST_OFF;
    endcase
  end

  // Output decode of the upcoming state so the output flops track the state register
  always_comb begin
    mode_d   = 2'b00;
    select_d = 1'b0;
    heat_d   = 1'b0;
    case (next_state)
      ST_ECO: begin
        mode_d = 2'b01;
        heat_d = 1'b1;
      end
      ST_BOOST: begin
        mode_d   = 2'b10;
        select_d = 1'b1;
        heat_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, dwell counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      dwell       <= DWELL_MAX;
      mode        <= 2'b00;
      mode_select <= 1'b0;
      heat_on     <= 1'b0;
    end else begin
      state       <= next_state;
      mode        <= mode_d;
      mode_select <= select_d;
      heat_on     <= heat_d;
      if (next_state != state)
        dwell <= '0;
      else if (!dwell_expired)
        dwell <= dwell + DW'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_heat_mode_sequencer.sv
// Self-checking bench: a behavioural reference model feeds a scoreboard queue,
// plus directed checks of the documented scenarios.
module tb_heat_mode_sequencer;

  localparam int TW   = 8;
  localparam int HY   = 2;
  localparam int BD   = 5;
  localparam int MD   = 16;
  localparam int TMAX = 255;

  localparam int S_OFF = 0, S_ECO = 1, S_BOOST = 2, S_LOCK = 3;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [TW-1:0] temp_meas;
  logic          temp_valid;
  logic [TW-1:0] setpoint;
  logic [1:0]    mode;
  logic          mode_select;
  logic          heat_on;
  logic [1:0]    state_o;

  heat_mode_sequencer #(
    .TEMP_W(TW), .HYST(HY), .BOOST_DELTA(BD), .MIN_DWELL(MD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .temp_meas(temp_meas),
    .temp_valid(temp_valid), .setpoint(setpoint), .mode(mode),
    .mode_select(mode_select), .heat_on(heat_on), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int md;
    int sel;
    int heat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_st = S_OFF;
  int   m_dw = MD;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: advance one clock given the inputs present at the edge
  task automatic model_advance(input int en, input int vld, input int tmp,
                               input int sp, input int rst);
    int lo, hi, def, ns, q;
    if (rst == 0) begin
      m_st = S_OFF;
      m_dw = MD;
      return;
    end
    lo  = (sp - HY < 0) ? 0 : sp - HY;
    hi  = (sp + HY > TMAX) ? TMAX : sp + HY;
    def = (tmp >= sp) ? 0 : sp - tmp;
    q   = (vld != 0 && en != 0 && m_dw == MD) ? 1 : 0;
    ns  = m_st;
    if (m_st == S_OFF) begin
      if (q != 0 && tmp < lo) ns = (def >= BD) ? S_BOOST : S_ECO;
    end else if (m_st == S_ECO || m_st == S_BOOST) begin
      if (en == 0) ns = S_OFF;
      else if (q != 0) begin
        if (tmp >= hi) ns = S_LOCK;
        else if (m_st == S_ECO && def >= BD) ns = S_BOOST;
        else if (m_st == S_BOOST && def < BD) ns = S_ECO;
      end
    end else begin
      if (m_dw == MD) ns = S_OFF;
    end
    if (ns != m_st) m_dw = 0;
    else if (m_dw < MD) m_dw = m_dw + 1;
    m_st = ns;
  endtask

  task automatic step(input int en, input int vld, input int tmp,
                      input int sp, input int rst);
    exp_t e, got;
    rst_n      = (rst != 0);
    enable     = (en != 0);
    temp_valid = (vld != 0);
    temp_meas  = TW'(tmp);
    setpoint   = TW'(sp);
    model_advance(en, vld, tmp, sp, rst);
    e.st   = m_st;
    e.md   = (m_st == S_ECO) ? 1 : (m_st == S_BOOST) ? 2 : 0;
    e.sel  = (m_st == S_BOOST) ? 1 : 0;
    e.heat = (m_st == S_ECO || m_st == S_BOOST) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check_eq("sb_state", int'(state_o), got.st);
    check_eq("sb_mode", int'(mode), got.md);
    check_eq("sb_select", int'(mode_select), got.sel);
    check_eq("sb_heat", int'(heat_on), got.heat);
  endtask

  task automatic idle(input int n, input int sp);
    for (int i = 0; i < n; i++) step(1, 0, 0, sp, 1);
  endtask

  task automatic expect_outs(input string tag, input int st, input int md,
                             input int sel, input int heat);
    check_eq({tag, "_state"}, int'(state_o), st);
    check_eq({tag, "_mode"}, int'(mode), md);
    check_eq({tag, "_select"}, int'(mode_select), sel);
    check_eq({tag, "_heat"}, int'(heat_on), heat);
  endtask

  initial begin
    int n, sp, tmp;
    rst_n = 1'b0; enable = 1'b1; temp_valid = 1'b0;
    temp_meas = '0; setpoint = 8'd100;
    #2;

    // Reset / idle: 99 is not below lo=98
    step(1, 0, 0, 100, 0);
    step(1, 0, 0, 100, 0);
    expect_outs("reset", S_OFF, 0, 0, 0);
    step(1, 1, 99, 100, 1);
    expect_outs("idle99", S_OFF, 0, 0, 0);

    // Eco entry then boost
    step(1, 1, 97, 100, 1);
    expect_outs("eco_entry", S_ECO, 1, 0, 1);
    idle(16, 100);
    step(1, 1, 94, 100, 1);
    expect_outs("boost_entry", S_BOOST, 2, 1, 1);

    // Back to ECO, then dwell gating
    idle(16, 100);
    step(1, 1, 97, 100, 1);
    expect_outs("boost_to_eco", S_ECO, 1, 0, 1);
    idle(4, 100);
    step(1, 1, 90, 100, 1);
    expect_outs("dwell_gate", S_ECO, 1, 0, 1);
    idle(11, 100);
    step(1, 1, 90, 100, 1);
    expect_outs("dwell_done", S_BOOST, 2, 1, 1);

    // Lockout and its fixed 17-cycle duration
    idle(16, 100);
    step(1, 1, 102, 100, 1);
    expect_outs("lockout", S_LOCK, 0, 0, 0);
    step(1, 1, 80, 100, 1);
    check_eq("lock_ignore", int'(state_o), S_LOCK);
    n = 1;
    while (state_o != 2'(S_OFF) && n < 40) begin
      step(1, 0, 0, 100, 1);
      n++;
    end
    check_eq("lockout_len", n, 17);

    // Disable mid-boost, then reset mid-eco
    idle(16, 100);
    step(1, 1, 94, 100, 1);
    expect_outs("boost_direct", S_BOOST, 2, 1, 1);
    idle(3, 100);
    step(0, 0, 0, 100, 1);
    expect_outs("disable", S_OFF, 0, 0, 0);
    step(0, 1, 90, 100, 1);
    check_eq("disable_hold", int'(state_o), S_OFF);
    idle(16, 100);
    step(1, 1, 97, 100, 1);
    check_eq("reenter_eco", int'(state_o), S_ECO);
    step(1, 1, 80, 100, 0);
    expect_outs("mid_reset", S_OFF, 0, 0, 0);
    step(1, 1, 97, 100, 1);
    check_eq("post_reset_first", int'(state_o), S_ECO);

    // Saturation of lo and hi
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 1);
    check_eq("lo_sat", int'(state_o), S_OFF);
    step(1, 1, 252, 255, 1);
    check_eq("eco_sp255", int'(state_o), S_ECO);
    idle(16, 255);
    step(1, 1, 255, 255, 1);
    check_eq("hi_sat", int'(state_o), S_LOCK);
    idle(17, 255);
    check_eq("hi_sat_off", int'(state_o), S_OFF);

    // Randomised traffic against the reference model
    sp = 100;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) sp = $urandom_range(0, 255);
      tmp = sp + $urandom_range(0, 20) - 10;
      if (tmp < 0) tmp = 0;
      if (tmp > TMAX) tmp = TMAX;
      step(($urandom_range(0, 19) != 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           tmp, sp,
           ($urandom_range(0, 99) != 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
